// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter: FSM states, grant owner, default width.
// No logic; types and constants only.
// No flow control.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        LDR_ACC = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_halfword_lane_steer.sv
// Halfword lane decode: lane enables, write-data steering and zero-extended read-data extract.
// Purely combinational, zero latency.
// No flow control; follows its inputs every cycle.
module halfword_lane_steer (
    input  logic        halfw,
    input  logic        lane_hi,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic        sel_hi,
    output logic        sel_lo,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    // Word accesses use both lanes; halfwords pick one lane and zero the other.
    always_comb begin
        sel_hi    = 1'b1;
        sel_lo    = 1'b1;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        if (halfw) begin
            if (lane_hi) begin
                sel_lo    = 1'b0;
                wdata_out = {wdata_in[15:0], 16'h0000};
                rdata_out = {16'h0000, rdata_in[31:16]};
            end else begin
                sel_hi    = 1'b0;
                wdata_out = {16'h0000, wdata_in[15:0]};
                rdata_out = {16'h0000, rdata_in[15:0]};
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / loader) arbiter onto one single-ported data RAM, round-robin on ties.
// Latency: req->ack 2 cycles uncontested, at most 4 contested; RAM driven in the grant cycle.
// Backpressure: requester holds req until its one-cycle ack; cpu_stall freezes the pipeline meanwhile.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_halfw,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ack,
    output logic [31:0]       ldr_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_sel_hi,
    output logic              ram_sel_lo,
    input  logic [31:0]       ram_rdata
);

    state_t            state;
    state_t            state_nxt;
    owner_t            last_grant;
    owner_t            win;
    logic              grant;
    logic              armed;

    logic              acc_halfw;
    logic              acc_lane_hi;
    logic [ADDR_W-1:0] addr_q;

    logic              mux_halfw;
    logic              mux_lane_hi;
    logic              mux_we;
    logic [31:0]       mux_wdata;
    logic [ADDR_W-1:0] mux_addr;

    logic              st_sel_hi;
    logic              st_sel_lo;
    logic [31:0]       st_wdata;
    logic [31:0]       st_rdata;

    // Address bits above the RAM window wrap; byte-offset bits carry no word information.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[0],
                                ldr_addr[31:ADDR_W+2], ldr_addr[1:0]};

    // Arbitration in IDLE: single requester wins outright, ties go to whoever did not win last.
    // 'armed' holds off any grant until the first clock edge after reset release.
    always_comb begin
        grant = 1'b0;
        win   = OWNER_CPU;
        if (armed && state == IDLE && (cpu_req || ldr_req)) begin
            grant = 1'b1;
            if (cpu_req && ldr_req)
                win = (last_grant == OWNER_CPU) ? OWNER_LDR : OWNER_CPU;
            else if (ldr_req)
                win = OWNER_LDR;
        end
    end

    // Next state: a grant moves to the owner's access state, every access state returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = (win == OWNER_CPU) ? CPU_ACC : LDR_ACC;
            CPU_ACC: state_nxt = IDLE;
            LDR_ACC: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner mux: live request fields while granting, latched lane info during the access state.
    always_comb begin
        mux_halfw   = acc_halfw;
        mux_lane_hi = acc_lane_hi;
        mux_we      = 1'b0;
        mux_wdata   = 32'h0;
        mux_addr    = addr_q;
        if (state == IDLE) begin
            if (win == OWNER_CPU) begin
                mux_halfw   = cpu_halfw;
                mux_lane_hi = cpu_addr[1];
                mux_we      = cpu_we;
                mux_wdata   = cpu_wdata;
                mux_addr    = cpu_addr[ADDR_W+1:2];
            end else begin
                mux_halfw   = 1'b0;
                mux_lane_hi = 1'b0;
                mux_we      = ldr_we;
                mux_wdata   = ldr_wdata;
                mux_addr    = ldr_addr[ADDR_W+1:2];
            end
        end
    end

    halfword_lane_steer u_steer (
        .halfw     (mux_halfw),
        .lane_hi   (mux_lane_hi),
        .wdata_in  (mux_wdata),
        .rdata_in  (ram_rdata),
        .sel_hi    (st_sel_hi),
        .sel_lo    (st_sel_lo),
        .wdata_out (st_wdata),
        .rdata_out (st_rdata)
    );

    // The RAM only sees an access in the grant cycle; otherwise strobes are low and the address holds.
    assign ram_we     = grant & mux_we;
    assign ram_sel_hi = grant & st_sel_hi;
    assign ram_sel_lo = grant & st_sel_lo;
    assign ram_wdata  = grant ? st_wdata : 32'h0;
    assign ram_addr   = grant ? mux_addr : addr_q;

    assign cpu_stall  = cpu_req & ~cpu_ack;

    // State register; reset parks in IDLE with the loader as last winner so the CPU wins first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= OWNER_LDR;
            armed      <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (grant)
                last_grant <= win;
        end
    end

    // Access bookkeeping: latch the granted access, then capture read data and pulse the ack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q      <= '0;
            acc_halfw   <= 1'b0;
            acc_lane_hi <= 1'b0;
            cpu_ack     <= 1'b0;
            ldr_ack     <= 1'b0;
            cpu_rdata   <= 32'h0;
            ldr_rdata   <= 32'h0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            if (grant) begin
                addr_q      <= mux_addr;
                acc_halfw   <= mux_halfw;
                acc_lane_hi <= mux_lane_hi;
            end
            if (state == CPU_ACC) begin
                cpu_rdata <= st_rdata;
                cpu_ack   <= 1'b1;
            end
            if (state == LDR_ACC) begin
                ldr_rdata <= st_rdata;
                ldr_ack   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle sequences, randomized two-port traffic.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
// The RAM is a behavioural synchronous memory; random traffic is scored against a word-array model.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req, cpu_we, cpu_halfw;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_ack;
    logic [31:0] cpu_rdata;
    logic        ldr_req, ldr_we;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        ldr_ack;
    logic [31:0] ldr_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we, ram_sel_hi, ram_sel_lo;
    logic [31:0] ram_rdata = 32'h0;

    logic [31:0] ram_mem [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        we;
        logic        halfw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [9:0]  exp_addr;
        logic        exp_hi;
        logic        exp_lo;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    mem_port_arbiter #(.ADDR_W(10)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_halfw  (cpu_halfw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_ack    (ldr_ack),
        .ldr_rdata  (ldr_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_sel_hi (ram_sel_hi),
        .ram_sel_lo (ram_sel_lo),
        .ram_rdata  (ram_rdata)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM: lane-masked write, read data valid the cycle after the address.
    always @(posedge CLK) begin
        if (ram_we) begin
            if (ram_sel_hi) ram_mem[ram_addr][31:16] <= ram_wdata[31:16];
            if (ram_sel_lo) ram_mem[ram_addr][15:0]  <= ram_wdata[15:0];
        end
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    endtask

    task automatic checkb(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%b required=%b", nm, act, exp);
    endtask

    task automatic wait_cpu_ack(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 10);
        checkb("cpu_ack_seen", cpu_ack, 1'b1);
    endtask

    task automatic do_reset();
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        RST     = 1'b1;
        #1;
        checkb("rst_cpu_ack", cpu_ack, 1'b0);
        checkb("rst_ldr_ack", ldr_ack, 1'b0);
        checkb("rst_ram_we", ram_we, 1'b0);
        checkb("rst_sel_hi", ram_sel_hi, 1'b0);
        checkb("rst_sel_lo", ram_sel_lo, 1'b0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_ldr_rdata", ldr_rdata, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick();
    endtask

    task automatic cpu_driver(input int n);
        logic        we, hw;
        logic [31:0] a, wd, exp;
        int          w, lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            we = 1'($urandom_range(0, 1));
            hw = 1'($urandom_range(0, 1));
            w  = 256 + int'($urandom_range(0, 127));
            a  = $urandom();
            a[11:2] = 10'(w);
            a[1] = hw ? 1'($urandom_range(0, 1)) : 1'b0;
            a[0] = 1'b0;
            wd = $urandom();
            cpu_we = we; cpu_halfw = hw; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!cpu_ack && lat < 10);
            checkb("rnd_cpu_ack", cpu_ack, 1'b1);
            checkb("rnd_cpu_lat", (lat >= 2 && lat <= 4), 1'b1);
            if (we) begin
                if (!hw)      ref_mem[w]        = wd;
                else if (a[1]) ref_mem[w][31:16] = wd[15:0];
                else          ref_mem[w][15:0]  = wd[15:0];
            end else begin
                exp = !hw ? ref_mem[w] :
                      (a[1] ? {16'h0, ref_mem[w][31:16]} : {16'h0, ref_mem[w][15:0]});
                check("rnd_cpu_rdata", cpu_rdata, exp);
            end
            cpu_req = 1'b0;
        end
    endtask

    task automatic ldr_driver(input int n);
        logic        we;
        logic [31:0] a, wd;
        int          w, lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            we = 1'($urandom_range(0, 1));
            w  = 384 + int'($urandom_range(0, 127));
            a  = $urandom();
            a[11:2] = 10'(w);
            a[1:0]  = 2'b00;
            wd = $urandom();
            ldr_we = we; ldr_addr = a; ldr_wdata = wd; ldr_req = 1'b1;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!ldr_ack && lat < 10);
            checkb("rnd_ldr_ack", ldr_ack, 1'b1);
            checkb("rnd_ldr_lat", (lat >= 2 && lat <= 4), 1'b1);
            if (we) ref_mem[w] = wd;
            else    check("rnd_ldr_rdata", ldr_rdata, ref_mem[w]);
            ldr_req = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;

        //            we    hw    addr          wdata         ram_addr hi    lo    ram_wdata     rdata
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 10'd4, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         10'd4, 1'b1, 1'b1, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0022, 32'h0000_1234, 10'd8, 1'b1, 1'b0, 32'h1234_0000, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0022, 32'h0,         10'd8, 1'b1, 1'b0, 32'h0,         32'h0000_1234};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_ABCD, 10'd8, 1'b0, 1'b1, 32'h0000_ABCD, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         10'd8, 1'b0, 1'b1, 32'h0,         32'h0000_ABCD};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         10'd8, 1'b1, 1'b1, 32'h0,         32'h1234_ABCD};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_1004, 32'hCAFE_F00D, 10'd1, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         10'd1, 1'b1, 1'b1, 32'h0,         32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         10'd0, 1'b1, 1'b1, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         10'd2, 1'b1, 1'b1, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0026, 32'hFFFF_5678, 10'd9, 1'b1, 1'b0, 32'h5678_0000, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         10'd9, 1'b1, 1'b1, 32'h0,         32'h5678_0000};

        RST = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        cpu_we = 1'b0; cpu_halfw = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ldr_we = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
        #1;
        do_reset();

        // Back-to-back store then load, request held across the first ack.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_halfw = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        check("b2b_st_addr", 32'(ram_addr), 32'd4);
        checkb("b2b_st_we", ram_we, 1'b1);
        checkb("b2b_st_hi", ram_sel_hi, 1'b1);
        checkb("b2b_st_lo", ram_sel_lo, 1'b1);
        check("b2b_st_wdata", ram_wdata, 32'hDEAD_BEEF);
        checkb("b2b_stall_c0", cpu_stall, 1'b1);
        tick();
        checkb("b2b_ack_c1", cpu_ack, 1'b0);
        checkb("b2b_we_c1", ram_we, 1'b0);
        tick();
        checkb("b2b_ack_c2", cpu_ack, 1'b1);
        checkb("b2b_stall_c2", cpu_stall, 1'b0);
        cpu_we = 1'b0; cpu_wdata = 32'h0;
        #1;
        checkb("b2b_ld_we", ram_we, 1'b0);
        check("b2b_ld_addr", 32'(ram_addr), 32'd4);
        tick();
        checkb("b2b_ack_c3", cpu_ack, 1'b0);
        tick();
        checkb("b2b_ack_c4", cpu_ack, 1'b1);
        check("b2b_ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_req = 1'b0;
        tick();

        // Vector table: isolated CPU accesses, each starting from an idle arbiter.
        for (int i = 0; i < 13; i++) begin
            cpu_req = 1'b1; cpu_we = vecs[i].we; cpu_halfw = vecs[i].halfw;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            #1;
            check($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
            checkb($sformatf("v%0d_hi", i), ram_sel_hi, vecs[i].exp_hi);
            checkb($sformatf("v%0d_lo", i), ram_sel_lo, vecs[i].exp_lo);
            checkb($sformatf("v%0d_we", i), ram_we, vecs[i].we);
            if (vecs[i].we) check($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].exp_wdata);
            wait_cpu_ack(lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
            if (!vecs[i].we) check($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
            cpu_req = 1'b0;
            #1;
            check($sformatf("v%0d_hold_addr", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
            checkb($sformatf("v%0d_idle_we", i), ram_we, 1'b0);
            checkb($sformatf("v%0d_idle_sel", i), ram_sel_hi | ram_sel_lo, 1'b0);
            tick();
        end

        // Request dropped mid-access, with fields changed: access completes unchanged, single ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_halfw = 1'b0; cpu_addr = 32'h10;
        #1;
        check("pe_addr", 32'(ram_addr), 32'd4);
        tick();
        cpu_req = 1'b0; cpu_halfw = 1'b1; cpu_addr = 32'h22;
        #1;
        checkb("pe_no_drive", ram_sel_hi | ram_sel_lo, 1'b0);
        tick();
        checkb("pe_ack", cpu_ack, 1'b1);
        check("pe_rdata", cpu_rdata, 32'hDEAD_BEEF);
        checkb("pe_stall", cpu_stall, 1'b0);
        tick();
        checkb("pe_ack_once", cpu_ack, 1'b0);

        // Both ports requesting continuously from reset: CPU, LDR, CPU, ... every two cycles.
        do_reset();
        cpu_we = 1'b0; cpu_halfw = 1'b0; cpu_addr = 32'h10;
        ldr_we = 1'b0; ldr_addr = 32'h20;
        cpu_req = 1'b1; ldr_req = 1'b1;
        #1;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) tick();
            checkb($sformatf("rr_cpu_ack_c%0d", c), cpu_ack, (c % 4 == 2));
            checkb($sformatf("rr_ldr_ack_c%0d", c), ldr_ack, (c % 4 == 0 && c > 0));
            checkb($sformatf("rr_stall_c%0d", c), cpu_stall, !(c % 4 == 2));
            if (c % 2 == 0)
                check($sformatf("rr_grant_addr_c%0d", c), 32'(ram_addr), (c % 4 == 0) ? 32'd4 : 32'd8);
            if (c % 4 == 0 && c > 0)
                check($sformatf("rr_ldr_rdata_c%0d", c), ldr_rdata, 32'h1234_ABCD);
        end

        // Reset pulse while the loader owns the RAM: no ack, outputs cleared, CPU wins next.
        tick();
        tick();
        tick();
        RST = 1'b1;
        #1;
        checkb("ra_ldr_ack", ldr_ack, 1'b0);
        checkb("ra_cpu_ack", cpu_ack, 1'b0);
        checkb("ra_ram_we", ram_we, 1'b0);
        checkb("ra_sel", ram_sel_hi | ram_sel_lo, 1'b0);
        check("ra_ram_addr", 32'(ram_addr), 32'h0);
        check("ra_cpu_rdata", cpu_rdata, 32'h0);
        check("ra_ldr_rdata", ldr_rdata, 32'h0);
        @(posedge CLK);
        #1;
        checkb("ra_ldr_ack_edge", ldr_ack, 1'b0);
        RST = 1'b0;
        #1;
        checkb("ra_no_early_grant", ram_sel_lo, 1'b0);
        tick();
        check("ra_cpu_first", 32'(ram_addr), 32'd4);
        checkb("ra_cpu_first_sel", ram_sel_lo, 1'b1);
        tick();
        tick();
        checkb("ra_cpu_ack", cpu_ack, 1'b1);
        checkb("ra_no_ldr_ack", ldr_ack, 1'b0);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();

        // Randomized concurrent traffic on disjoint word regions.
        fork
            cpu_driver(30);
            ldr_driver(30);
        join
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width driven to the data RAM (byte address bits [ADDR_W+1:2]).
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port cpu_req, input, 1, MEM-stage access request, held until cpu_ack.
REQ-005 SHALL have port cpu_we, input, 1, CPU store (1) or load (0).
REQ-006 SHALL have port cpu_halfw, input, 1, halfword access (1) or word access (0).
REQ-007 SHALL have port cpu_addr, input, 32, CPU byte address.
REQ-008 SHALL have port cpu_wdata, input, 32, CPU store data; the halfword is in [15:0].
REQ-009 SHALL have port cpu_stall, output, 1, freezes the pipeline while cpu_req is pending and not acked.
REQ-010 SHALL have port cpu_ack, output, 1, one-cycle pulse marking access complete.
REQ-011 SHALL have port cpu_rdata, output, 32, load data, valid when cpu_ack is high.
REQ-012 SHALL have port ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata, with the same widths and meaning for the loader/debug port; the loader issues word accesses only.
REQ-013 SHALL have port ram_addr, output, ADDR_W, word address to the RAM.
REQ-014 SHALL have port ram_wdata, output, 32, lane-steered write data.
REQ-015 SHALL have port ram_we, output, 1, RAM write strobe.
REQ-016 SHALL have port ram_sel_hi and ram_sel_lo, output, 1 each, upper and lower halfword lane enables.
REQ-017 SHALL have port ram_rdata, input, 32, RAM read data, valid one cycle after the address is presented.

Function
REQ-018 SHALL use FSM states IDLE, CPU_ACC, LDR_ACC, with exactly one RAM access per grant.
REQ-019 In IDLE, SHALL grant on any request, using round-robin on ties via the last_grant register (CPU preferred after reset).
REQ-020 SHALL drive the RAM in the grant cycle (IDLE->x_ACC edge); in x_ACC SHALL capture ram_rdata into x_rdata, pulse x_ack, and return to IDLE.
REQ-021 Latency from req to ack SHALL be 2 cycles when uncontested and at most 4 when contested.
REQ-022 In IDLE with no request, ram_we SHALL be 0, sel_hi and sel_lo SHALL be 0, and ram_addr SHALL hold its last value.
REQ-023 Word access SHALL set sel_hi=sel_lo=1 and ram_wdata=wdata.
REQ-024 Halfword access SHALL use addr[1]=0 for the lower lane (sel_lo=1, sel_hi=0, ram_wdata[15:0]=wdata[15:0]) and addr[1]=1 for the upper lane (sel_hi=1, sel_lo=0, ram_wdata[31:16]=wdata[15:0]); the unused lane SHALL be driven 0.
REQ-025 A halfword load SHALL return the selected lane zero-extended in cpu_rdata[15:0].
REQ-026 cpu_stall SHALL equal cpu_req & ~cpu_ack combinationally.
REQ-027 A requester that deasserts req before ack SHALL be treated as a protocol error: the in-flight access SHALL complete, and ack SHALL still pulse.
REQ-028 A requester holding req after ack SHALL be treated as a new request, arbitrated again in IDLE.
REQ-029 ram_addr SHALL be taken from addr[ADDR_W+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-030 Requests SHALL be sampled only in IDLE; changes to request inputs in x_ACC SHALL be ignored.

Reset
REQ-031 RST assertion SHALL immediately force state IDLE, last_grant=LDR (so the CPU wins first), acks=0, ram_we=0, sel=0, ram_addr=0, and rdata regs=0.
REQ-032 Reset during x_ACC SHALL abort the access with no ack; requesters SHALL reissue after reset.
REQ-033 Deassertion SHALL be usable asynchronously; the first grant SHALL occur no earlier than the first rising edge after deassertion.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/CPU_ACC/LDR_ACC), the grant-owner encoding, and ADDR_W_DEFAULT=10.
REQ-035 Lane decode and steering (REQ-023..025) SHALL be one combinational sub-module, halfword_lane_steer, instantiated once on the muxed winner.

Verification
REQ-036 CPU word store 0xDEADBEEF to byte address 0x10, then load -> ram_addr=4, sel=11, cpu_ack at cycles 2 and 4, cpu_rdata=0xDEADBEEF.
REQ-037 CPU halfword store 0x1234 to byte address 0x22 -> sel_hi=1, sel_lo=0, ram_wdata=0x12340000; a halfword load from 0x22 returns 0x00001234.
REQ-038 cpu_req and ldr_req asserted continuously from reset -> grants alternate CPU, LDR, CPU, ...; each ack arrives within 4 cycles; cpu_stall is high exactly until each cpu_ack.
REQ-039 RST pulsed while in LDR_ACC -> no ldr_ack, all outputs at reset values in the same cycle, and the next contested grant goes to the CPU.
REQ-040 Address 0x1004 with ADDR_W=10 -> ram_addr=1 (wrap), and no other side effect.
